// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with fixed-priority writes,
// an optional hardwired zero entry and a sequential bulk-clear engine.
//
// Parameters:
//   XLEN     data width per entry
//   DEPTH    number of entries (power of two, >= 2)
//   NR       number of combinational read ports (>= 1)
//   NW       number of synchronous write ports (>= 1)
//   ZERO_REG 1 = entry 0 reads as 0 and ignores writes
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset, clears storage and the clear engine
//   we        write enables, bit i belongs to write port i
//   wa        write addresses, port i at [i*AW +: AW]
//   wd        write data, port i at [i*XLEN +: XLEN]
//   ra        read addresses, port j at [j*AW +: AW]
//   rd        read data, port j at [j*XLEN +: XLEN]
//   clr_req   start a bulk clear (sampled only when idle)
//   clr_busy  high while the clear engine walks the entries
//   clr_done  one-cycle pulse after the last entry has been cleared
//
// Build option:
//   REGFILE_MP_BYPASS_EN  when defined, reads forward same-cycle write data
//                         (highest-indexed matching port) while idle.

module regfile_mp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NR       = 2,
  parameter int unsigned NW       = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NW-1:0]        we,
  input  logic [NW*$clog2(DEPTH)-1:0] wa,
  input  logic [NW*XLEN-1:0]   wd,
  input  logic [NR*$clog2(DEPTH)-1:0] ra,
  output logic [NR*XLEN-1:0]   rd,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] CntLast = AW'(DEPTH - 1);
  localparam bit HasZero = (ZERO_REG != 0);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [XLEN-1:0]   mem_d [DEPTH];

  // Clear engine next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign clr_busy = (state_q == StClear);
  assign clr_done = done_q;

  // Storage next-state. Ports are applied in ascending order so the highest
  // enabled port to a given address overrides lower ones. The clear engine
  // owns the array exclusively while running.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      mem_d[k] = mem_q[k];
    end
    if (state_q == StClear) begin
      mem_d[cnt_q] = '0;
    end else begin
      for (int i = 0; i < int'(NW); i++) begin
        if (we[i] && !(HasZero && (wa[i*AW +: AW] == '0))) begin
          mem_d[wa[i*AW +: AW]] = wd[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  // Read ports.
  for (genvar j = 0; j < int'(NR); j++) begin : g_rd
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rval;

    assign raddr = ra[j*AW +: AW];

    always_comb begin
      rval = mem_q[raddr];
`ifdef REGFILE_MP_BYPASS_EN
      // Forward in-flight write data; later ports take precedence.
      if (state_q == StIdle) begin
        for (int i = 0; i < int'(NW); i++) begin
          if (we[i] && (wa[i*AW +: AW] == raddr)) begin
            rval = wd[i*XLEN +: XLEN];
          end
        end
      end
`endif
      if (HasZero && (raddr == '0)) begin
        rval = '0;
      end
    end

    assign rd[j*XLEN +: XLEN] = rval;
  end

endmodule
